// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers and limits for the pipelined N:1 mux tree.
package mux_tree_pipe_pkg;

    localparam int MAX_N_IN = 256;

    // Ceiling log2, used to size the select and the number of levels.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int b = 0; b < 32; b++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

    // Number of set bits among the lowest n bits (pipeline latency of a mask).
    function automatic int popcount(input logic [31:0] bits, input int n);
        int count;
        count = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < n && bits[b]) begin
                count = count + 1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_stage.sv
// One 2:1 reduction level of the mux tree, with an optional register that
// carries the reduced data, the still-unused select bits and the valid flag
// together so every word keeps its own select.
module mux_tree_pipe_stage
    import mux_tree_pipe_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int N_CAND = 2,
    parameter int SEL_W  = 1,
    parameter bit REG    = 1'b0,
    localparam int N_OUT  = N_CAND / 2,
    localparam int SOUT_W = (SEL_W > 1) ? SEL_W - 1 : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic [N_CAND*WIDTH-1:0]  d_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     valid_in,
    output logic [N_OUT*WIDTH-1:0]   d_out,
    output logic [SOUT_W-1:0]        sel_out,
    output logic                     valid_out
);

    logic [N_OUT*WIDTH-1:0] mux_d;
    logic [SOUT_W-1:0]      rest_sel;

    // Pairwise 2:1 selection: sel_in[0]=1 takes the odd candidate.
    always_comb begin
        mux_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            mux_d[j*WIDTH +: WIDTH] = sel_in[0] ? d_in[(2*j+1)*WIDTH +: WIDTH]
                                                : d_in[(2*j)*WIDTH +: WIDTH];
        end
    end

    // The consumed LSB is dropped; the last level has nothing left to forward.
    if (SEL_W > 1) begin : g_rest
        assign rest_sel = sel_in[SEL_W-1:1];
    end else begin : g_no_rest
        assign rest_sel = '0;
    end

    if (REG) begin : g_reg
        // Data, remaining select and valid advance together only while ce=1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_out     <= '0;
                sel_out   <= '0;
                valid_out <= 1'b0;
            end else if (ce) begin
                d_out     <= mux_d;
                sel_out   <= rest_sel;
                valid_out <= valid_in;
            end
        end
    end else begin : g_comb
        assign d_out     = mux_d;
        assign sel_out   = rest_sel;
        assign valid_out = valid_in;
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Parametrised N_IN:1 mux built as a chain of 2:1 levels; PIPE_MASK bit k
// places a register after level k. Select and valid ride along with data.
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int         WIDTH     = 1,
    parameter int         N_IN      = 8,
    parameter logic [7:0] PIPE_MASK = 8'b100,
    localparam int LEVELS = (clog2(N_IN) < 1) ? 1 : clog2(N_IN)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CE,
    input  logic [N_IN*WIDTH-1:0]   I,
    input  logic [LEVELS-1:0]       S,
    input  logic                    VALID_IN,
    output logic [WIDTH-1:0]        O,
    output logic                    VALID_OUT
);

    if (N_IN < 2 || N_IN > MAX_N_IN || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
        $fatal(1, "mux_tree_pipe: N_IN=%0d must be a power of two in 2..%0d",
               N_IN, MAX_N_IN);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NC  = N_IN >> k;
        localparam int SW  = LEVELS - k;
        localparam int SOW = (SW > 1) ? SW - 1 : 1;

        logic [NC*WIDTH-1:0]     d_in;
        logic [SW-1:0]           s_in;
        logic                    v_in;
        logic [(NC/2)*WIDTH-1:0] d_out;
        logic [SOW-1:0]          s_out;
        logic                    v_out;

        if (k == 0) begin : g_first
            assign d_in = I;
            assign s_in = S;
            assign v_in = VALID_IN;
        end else begin : g_next
            assign d_in = g_lvl[k-1].d_out;
            assign s_in = g_lvl[k-1].s_out;
            assign v_in = g_lvl[k-1].v_out;
        end

        mux_tree_pipe_stage #(
            .WIDTH  (WIDTH),
            .N_CAND (NC),
            .SEL_W  (SW),
            .REG    (PIPE_MASK[k])
        ) u_stage (
            .clk       (CLK),
            .rst_n     (RST_N),
            .ce        (CE),
            .d_in      (d_in),
            .sel_in    (s_in),
            .valid_in  (v_in),
            .d_out     (d_out),
            .sel_out   (s_out),
            .valid_out (v_out)
        );
    end

    // The final level forwards a constant-zero select that nothing needs.
    logic sel_unused;
    assign sel_unused = ^g_lvl[LEVELS-1].s_out;

    assign O         = g_lvl[LEVELS-1].d_out;
    assign VALID_OUT = g_lvl[LEVELS-1].v_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe in three configurations:
//   A: WIDTH=8, N_IN=8,   PIPE_MASK=101  (latency 2)
//   B: WIDTH=1, N_IN=2,   PIPE_MASK=0    (combinational)
//   C: WIDTH=4, N_IN=256, PIPE_MASK=FF   (latency 8)
module tb_mux_tree_pipe;

    logic clk;
    int   checks;
    int   errors;

    logic        a_rst_n, a_ce, a_vin, a_vout;
    logic [63:0] a_i;
    logic [2:0]  a_s;
    logic [7:0]  a_o;

    logic        b_rst_n, b_ce, b_vin, b_vout;
    logic [1:0]  b_i;
    logic [0:0]  b_s;
    logic [0:0]  b_o;

    logic          c_rst_n, c_ce, c_vin, c_vout;
    logic [1023:0] c_i;
    logic [7:0]    c_s;
    logic [3:0]    c_o;

    mux_tree_pipe #(.WIDTH(8), .N_IN(8), .PIPE_MASK(8'b0000_0101)) u_a (
        .CLK(clk), .RST_N(a_rst_n), .CE(a_ce), .I(a_i), .S(a_s),
        .VALID_IN(a_vin), .O(a_o), .VALID_OUT(a_vout)
    );

    mux_tree_pipe #(.WIDTH(1), .N_IN(2), .PIPE_MASK(8'b0000_0000)) u_b (
        .CLK(clk), .RST_N(b_rst_n), .CE(b_ce), .I(b_i), .S(b_s),
        .VALID_IN(b_vin), .O(b_o), .VALID_OUT(b_vout)
    );

    mux_tree_pipe #(.WIDTH(4), .N_IN(256), .PIPE_MASK(8'hFF)) u_c (
        .CLK(clk), .RST_N(c_rst_n), .CE(c_ce), .I(c_i), .S(c_s),
        .VALID_IN(c_vin), .O(c_o), .VALID_OUT(c_vout)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver for config A: input j = base + j.
    task automatic drive_a(input logic [7:0] base, input logic [2:0] sel, input logic v);
        for (int j = 0; j < 8; j++) begin
            a_i[j*8 +: 8] = base + 8'(j);
        end
        a_s   = sel;
        a_vin = v;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (a_o !== 8'h00) begin errors++; $display("FAIL reset_a_o: got %h want 00", a_o); end
        checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b want 0", a_vout); end
        checks++; if (c_o !== 4'h0) begin errors++; $display("FAIL reset_c_o: got %h want 0", c_o); end
        checks++; if (c_vout !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b want 0", c_vout); end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        c_rst_n = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_sweep();
        logic [7:0] exp_o;
        logic       exp_v;
        drive_a(8'h10, 3'd0, 1'b0);
        step(); step();
        for (int n = 0; n < 12; n++) begin
            step();
            if (n >= 2 && n < 10) begin
                exp_o = 8'h10 + 8'(n - 2);
                exp_v = 1'b1;
            end else begin
                exp_o = 8'h10;
                exp_v = 1'b0;
            end
            checks++;
            if (a_vout !== exp_v) begin
                errors++; $display("FAIL sweep_valid n=%0d: got %b want %b", n, a_vout, exp_v);
            end
            if (n >= 2) begin
                checks++;
                if (a_o !== exp_o) begin
                    errors++; $display("FAIL sweep_o n=%0d: got %h want %h", n, a_o, exp_o);
                end
            end
            if (n < 8) drive_a(8'h10, 3'(n), 1'b1);
            else       drive_a(8'h10, 3'd0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        step(); drive_a(8'hA0, 3'd3, 1'b1);
        step(); drive_a(8'hB0, 3'd6, 1'b1);
        step();
        checks++; if (a_o !== 8'hA3 || a_vout !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %h/%b want a3/1", a_o, a_vout);
        end
        drive_a(8'hC0, 3'd0, 1'b0);
        step();
        checks++; if (a_o !== 8'hB6 || a_vout !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got %h/%b want b6/1", a_o, a_vout);
        end
        step();
        checks++; if (a_o !== 8'hC0 || a_vout !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got %h/%b want c0/0", a_o, a_vout);
        end
    endtask

    task automatic test_ce_hold();
        logic [7:0] base_t [10] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hC0, 8'hC0};
        logic [2:0] sel_t  [10] = '{3'd1, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
        logic       v_t    [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ce_t   [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_o  [10] = '{8'h00, 8'h00, 8'h51, 8'h62, 8'h62, 8'h62, 8'h62, 8'h75, 8'hB7, 8'hC0};
        logic       exp_v  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 2) begin
                checks++;
                if (a_o !== exp_o[i] || a_vout !== exp_v[i]) begin
                    errors++; $display("FAIL ce_hold i=%0d: got %h/%b want %h/%b",
                                       i, a_o, a_vout, exp_o[i], exp_v[i]);
                end
            end
            drive_a(base_t[i], sel_t[i], v_t[i]);
            a_ce = ce_t[i];
        end
    endtask

    task automatic test_reset_mid();
        step(); drive_a(8'hD0, 3'd4, 1'b1);
        step(); drive_a(8'hE0, 3'd1, 1'b1);
        step();
        checks++; if (a_o !== 8'hD4 || a_vout !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got %h/%b want d4/1", a_o, a_vout);
        end
        drive_a(8'hF0, 3'd2, 1'b1);
        #2;
        a_rst_n = 1'b0;
        #1;
        checks++; if (a_o !== 8'h00 || a_vout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got %h/%b want 00/0", a_o, a_vout);
        end
        step();
        checks++; if (a_o !== 8'h00 || a_vout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_held: got %h/%b want 00/0", a_o, a_vout);
        end
        drive_a(8'h00, 3'd0, 1'b0);
        #2;
        a_rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (a_o !== 8'h00 || a_vout !== 1'b0) begin
                errors++; $display("FAIL rst_mid_stale n=%0d: got %h/%b want 00/0", n, a_o, a_vout);
            end
        end
    endtask

    task automatic test_comb();
        logic [7:0] tt;
        logic [3:0] idx;
        tt = 8'hCA;   // index {s,i1,i0}
        for (int n = 0; n < 16; n++) begin
            idx   = 4'(n);
            b_i   = idx[1:0];
            b_s   = idx[2];
            b_vin = idx[3];
            #1;
            checks++;
            if (b_o[0] !== tt[idx[2:0]]) begin
                errors++; $display("FAIL comb_o n=%0d: got %b want %b", n, b_o, tt[idx[2:0]]);
            end
            checks++;
            if (b_vout !== idx[3]) begin
                errors++; $display("FAIL comb_valid n=%0d: got %b want %b", n, b_vout, idx[3]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] exp_q[$];
        logic [4:0] exp_w;
        for (int n = 0; n < 8; n++) exp_q.push_back(5'b0);
        for (int n = 0; n < 10000; n++) begin
            step();
            exp_w = exp_q.pop_front();
            checks++;
            if ({c_vout, c_o} !== exp_w) begin
                errors++; $display("FAIL random n=%0d: got %b/%h want %b/%h",
                                   n, c_vout, c_o, exp_w[4], exp_w[3:0]);
            end
            for (int w = 0; w < 32; w++) c_i[w*32 +: 32] = $urandom();
            c_s   = 8'($urandom_range(0, 255));
            c_vin = 1'($urandom_range(0, 1));
            exp_q.push_back({c_vin, c_i[int'(c_s)*4 +: 4]});
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        a_ce    = 1'b1; b_ce    = 1'b1; c_ce    = 1'b1;
        a_i = '0; a_s = '0; a_vin = 1'b0;
        b_i = '0; b_s = '0; b_vin = 1'b0;
        c_i = '0; c_s = '0; c_vin = 1'b0;

        test_reset();
        test_sweep();
        test_back_to_back();
        test_ce_hold();
        test_reset_mid();
        test_comb();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
